// File: rtl/instruction_decode.sv
// Decode stage: registers fetched PC/instruction pairs, decodes them for execute,
// and expands LDM/STM into one micro-op per listed register while holding fetch.
module instruction_decode (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  input  logic        valid_i,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [3:0]  cond_o,
  output logic [2:0]  class_o,
  output logic [3:0]  opc_o,
  output logic [3:0]  rn_o,
  output logic [3:0]  rd_o,
  output logic [3:0]  rs_o,
  output logic [3:0]  rm_o,
  output logic [31:0] imm_o,
  output logic        set_flags_o,
  output logic        load_o,
  output logic        link_o,
  output logic        uop_last_o
);

  localparam logic [2:0] CLS_DP     = 3'd0;
  localparam logic [2:0] CLS_MUL    = 3'd1;
  localparam logic [2:0] CLS_SINGLE = 3'd2;
  localparam logic [2:0] CLS_BLOCK  = 3'd3;
  localparam logic [2:0] CLS_BRANCH = 3'd4;
  localparam logic [2:0] CLS_SWI    = 3'd5;
  localparam logic [2:0] CLS_UNDEF  = 3'd6;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BLOCK = 1'b1;

  logic [0:0]  state;
  logic [15:0] pending;
  logic [3:0]  uop_cnt;

  logic [2:0]  dec_class;
  logic [3:0]  dec_rn;
  logic [3:0]  dec_rd;
  logic [31:0] dec_imm;
  logic        dec_sf;
  logic        dec_ld;
  logic        dec_lk;

  logic [15:0] list;
  logic [15:0] list_rest;
  logic [15:0] pending_rest;
  logic [31:0] imm8;
  logic [4:0]  rot_amt;
  logic [31:0] rot_imm;

  // x & (x-1) clears the lowest set bit, i.e. the register just emitted
  assign list         = instr_i[15:0];
  assign list_rest    = list & (list - 16'd1);
  assign pending_rest = pending & (pending - 16'd1);

  assign imm8    = {24'b0, instr_i[7:0]};
  assign rot_amt = {instr_i[11:8], 1'b0};
  assign rot_imm = (imm8 >> rot_amt) | (imm8 << (6'd32 - {1'b0, rot_amt}));

  assign stall_o = (state == BLOCK);

  function automatic logic [3:0] lowest_bit(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  always_comb begin
    dec_class = CLS_UNDEF;
    dec_rn    = instr_i[19:16];
    dec_rd    = instr_i[15:12];
    dec_imm   = 32'd0;
    dec_sf    = 1'b0;
    dec_ld    = 1'b0;
    dec_lk    = 1'b0;
    if (instr_i[27:22] == 6'b000000 && instr_i[7:4] == 4'b1001) begin
      dec_class = CLS_MUL;
      dec_rd    = instr_i[19:16];
      dec_rn    = instr_i[15:12];
      dec_sf    = instr_i[20];
    end else if (instr_i[27:26] == 2'b00) begin
      dec_class = CLS_DP;
      dec_sf    = instr_i[20];
      if (instr_i[25]) dec_imm = rot_imm;
    end else if (instr_i[27:26] == 2'b01) begin
      if (!(instr_i[25] && instr_i[4])) begin
        dec_class = CLS_SINGLE;
        dec_ld    = instr_i[20];
        if (!instr_i[25]) dec_imm = {20'b0, instr_i[11:0]};
      end
    end else if (instr_i[27:25] == 3'b100) begin
      if (list != 16'd0) begin
        dec_class = CLS_BLOCK;
        dec_ld    = instr_i[20];
      end
    end else if (instr_i[27:25] == 3'b101) begin
      dec_class = CLS_BRANCH;
      dec_lk    = instr_i[24];
      dec_imm   = {{6{instr_i[23]}}, instr_i[23:0], 2'b00};
    end else if (instr_i[27:24] == 4'b1111) begin
      dec_class = CLS_SWI;
    end
  end

  // In BLOCK only rd/imm/last change; the remaining fields keep the block instruction's decode
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      pending     <= 16'd0;
      uop_cnt     <= 4'd0;
      valid_o     <= 1'b0;
      pc_o        <= 32'd0;
      cond_o      <= 4'd0;
      class_o     <= 3'd0;
      opc_o       <= 4'd0;
      rn_o        <= 4'd0;
      rd_o        <= 4'd0;
      rs_o        <= 4'd0;
      rm_o        <= 4'd0;
      imm_o       <= 32'd0;
      set_flags_o <= 1'b0;
      load_o      <= 1'b0;
      link_o      <= 1'b0;
      uop_last_o  <= 1'b1;
    end else if (flush_i) begin
      state   <= IDLE;
      pending <= 16'd0;
      uop_cnt <= 4'd0;
      valid_o <= 1'b0;
    end else if (!stall_i) begin
      if (state == BLOCK) begin
        valid_o <= 1'b1;
        rd_o    <= lowest_bit(pending);
        imm_o   <= {26'b0, uop_cnt, 2'b00};
        uop_cnt <= uop_cnt + 4'd1;
        pending <= pending_rest;
        if (pending_rest == 16'd0) begin
          uop_last_o <= 1'b1;
          state      <= IDLE;
        end
      end else if (valid_i) begin
        valid_o     <= 1'b1;
        pc_o        <= pc_i;
        cond_o      <= instr_i[31:28];
        class_o     <= dec_class;
        opc_o       <= instr_i[24:21];
        rn_o        <= dec_rn;
        rd_o        <= dec_rd;
        rs_o        <= instr_i[11:8];
        rm_o        <= instr_i[3:0];
        imm_o       <= dec_imm;
        set_flags_o <= dec_sf;
        load_o      <= dec_ld;
        link_o      <= dec_lk;
        uop_last_o  <= 1'b1;
        if (dec_class == CLS_BLOCK) begin
          rd_o <= lowest_bit(list);
          if (list_rest != 16'd0) begin
            uop_last_o <= 1'b0;
            pending    <= list_rest;
            uop_cnt    <= 4'd1;
            state      <= BLOCK;
          end
        end
      end else begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instruction_decode.sv
// Self-checking bench for instruction_decode: directed vector table, block-transfer
// corner sequences, and random traffic against a micro-op queue reference model.
module tb_instruction_decode;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_i;
  logic [31:0] instr_i;
  logic        valid_i;
  logic        stall_i;
  logic        flush_i;
  logic        stall_o;
  logic        valid_o;
  logic [31:0] pc_o;
  logic [3:0]  cond_o;
  logic [2:0]  class_o;
  logic [3:0]  opc_o;
  logic [3:0]  rn_o;
  logic [3:0]  rd_o;
  logic [3:0]  rs_o;
  logic [3:0]  rm_o;
  logic [31:0] imm_o;
  logic        set_flags_o;
  logic        load_o;
  logic        link_o;
  logic        uop_last_o;

  int total = 0;
  int bad   = 0;

  instruction_decode dut (
    .clk(clk), .rst_n(rst_n), .pc_i(pc_i), .instr_i(instr_i), .valid_i(valid_i),
    .stall_i(stall_i), .flush_i(flush_i), .stall_o(stall_o), .valid_o(valid_o),
    .pc_o(pc_o), .cond_o(cond_o), .class_o(class_o), .opc_o(opc_o), .rn_o(rn_o),
    .rd_o(rd_o), .rs_o(rs_o), .rm_o(rm_o), .imm_o(imm_o), .set_flags_o(set_flags_o),
    .load_o(load_o), .link_o(link_o), .uop_last_o(uop_last_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [2:0]  cls;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [31:0] imm;
    logic        sf;
    logic        ld;
    logic        lk;
  } vec_t;

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [3:0]  cond;
    logic [2:0]  cls;
    logic [3:0]  opc;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [3:0]  rm;
    logic [31:0] imm;
    logic        sf;
    logic        ld;
    logic        lk;
    logic        last;
  } uop_t;

  vec_t vecs[13];
  uop_t cur;
  uop_t rem[$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  // Drives inputs, lets one rising edge pass, and returns 1 time unit later for sampling
  task automatic applyStimulus(input logic v, input logic [31:0] w, input logic [31:0] pc,
                               input logic st, input logic fl);
    valid_i = v;
    instr_i = w;
    pc_i    = pc;
    stall_i = st;
    flush_i = fl;
    @(posedge clk);
    #1;
  endtask

  // Reference: list every micro-op an instruction produces, in emission order
  function automatic void expand(input logic [31:0] w, input logic [31:0] pc);
    uop_t u;
    int nbits;
    int n;
    int off;
    logic [31:0] v8;
    u.valid = 1'b1; u.pc = pc; u.cond = w[31:28]; u.opc = w[24:21];
    u.rn = w[19:16]; u.rd = w[15:12]; u.rs = w[11:8]; u.rm = w[3:0];
    u.imm = 32'd0; u.sf = 1'b0; u.ld = 1'b0; u.lk = 1'b0; u.last = 1'b1; u.cls = 3'd6;
    if (w[27:22] == 6'b000000 && w[7:4] == 4'b1001) begin
      u.cls = 3'd1; u.rd = w[19:16]; u.rn = w[15:12]; u.sf = w[20];
    end else if (w[27:26] == 2'b00) begin
      u.cls = 3'd0; u.sf = w[20];
      if (w[25]) begin
        v8 = {24'b0, w[7:0]};
        for (int i = 0; i < 2 * int'(w[11:8]); i++) v8 = {v8[0], v8[31:1]};
        u.imm = v8;
      end
    end else if (w[27:26] == 2'b01) begin
      if (!(w[25] && w[4])) begin
        u.cls = 3'd2; u.ld = w[20];
        if (!w[25]) u.imm = {20'b0, w[11:0]};
      end
    end else if (w[27:25] == 3'b100) begin
      if (w[15:0] != 16'd0) begin
        u.cls = 3'd3; u.ld = w[20];
      end
    end else if (w[27:25] == 3'b101) begin
      u.cls = 3'd4; u.lk = w[24];
      off = int'(w[23:0]);
      if (off >= (1 << 23)) off = off - (1 << 24);
      u.imm = off * 4;
    end else if (w[27:24] == 4'hF) begin
      u.cls = 3'd5;
    end
    if (u.cls == 3'd3) begin
      nbits = 0;
      for (int i = 0; i < 16; i++) if (w[i]) nbits++;
      n = 0;
      for (int r = 0; r < 16; r++) begin
        if (w[r]) begin
          u.rd   = 4'(r);
          u.imm  = 4 * n;
          u.last = (n == nbits - 1);
          rem.push_back(u);
          n++;
        end
      end
    end else begin
      rem.push_back(u);
    end
  endfunction

  function automatic void model_edge(input logic v, input logic [31:0] w, input logic [31:0] pc,
                                     input logic st, input logic fl);
    if (fl) begin
      cur.valid = 1'b0;
      rem.delete();
    end else if (!st) begin
      if (rem.size() > 0) begin
        cur = rem.pop_front();
      end else if (v) begin
        expand(w, pc);
        cur = rem.pop_front();
      end else begin
        cur.valid = 1'b0;
      end
    end
  endfunction

  initial begin
    logic [31:0] w;
    logic [31:0] pc;
    logic        v;
    logic        st;
    logic        fl;
    int          sel;

    //          instr         pc            cls   rn    rd    imm           sf    ld    lk
    vecs[0]  = '{32'hE3A014FF, 32'h100, 3'd0, 4'h0, 4'h1, 32'hFF000000, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{32'hEAFFFFFE, 32'h104, 3'd4, 4'hF, 4'hF, 32'hFFFFFFF8, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{32'hE0000291, 32'h108, 3'd1, 4'h0, 4'h0, 32'h0,        1'b0, 1'b0, 1'b0};
    vecs[3]  = '{32'hE0910002, 32'h10C, 3'd0, 4'h1, 4'h0, 32'h0,        1'b1, 1'b0, 1'b0};
    vecs[4]  = '{32'hE5912004, 32'h110, 3'd2, 4'h1, 4'h2, 32'h4,        1'b0, 1'b1, 1'b0};
    vecs[5]  = '{32'hEF000011, 32'h114, 3'd5, 4'h0, 4'h0, 32'h0,        1'b0, 1'b0, 1'b0};
    vecs[6]  = '{32'hEB000010, 32'h118, 3'd4, 4'h0, 4'h0, 32'h40,       1'b0, 1'b0, 1'b1};
    vecs[7]  = '{32'hE7F000F0, 32'h11C, 3'd6, 4'h0, 4'h0, 32'h0,        1'b0, 1'b0, 1'b0};
    vecs[8]  = '{32'hE8900000, 32'h120, 3'd6, 4'h0, 4'h0, 32'h0,        1'b0, 1'b0, 1'b0};
    vecs[9]  = '{32'hE8900100, 32'h124, 3'd3, 4'h0, 4'h8, 32'h0,        1'b0, 1'b1, 1'b0};
    vecs[10] = '{32'hEE000000, 32'h128, 3'd6, 4'h0, 4'h0, 32'h0,        1'b0, 1'b0, 1'b0};
    vecs[11] = '{32'hE3A0002A, 32'h12C, 3'd0, 4'h0, 4'h0, 32'h2A,       1'b0, 1'b0, 1'b0};
    vecs[12] = '{32'hE7912003, 32'h130, 3'd2, 4'h1, 4'h2, 32'h0,        1'b0, 1'b1, 1'b0};

    rst_n = 1'b0;
    applyStimulus(1'b1, 32'hE3A014FF, 32'h100, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hE3A014FF, 32'h100, 1'b0, 1'b0);
    checkOutput("rst_valid", valid_o, 0);
    checkOutput("rst_stall", stall_o, 0);
    checkOutput("rst_pc", pc_o, 0);
    checkOutput("rst_imm", imm_o, 0);
    checkOutput("rst_last", uop_last_o, 1);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      applyStimulus(1'b1, vecs[i].instr, vecs[i].pc, 1'b0, 1'b0);
      checkOutput($sformatf("v%0d_valid", i), valid_o, 1);
      checkOutput($sformatf("v%0d_pc", i), pc_o, vecs[i].pc);
      checkOutput($sformatf("v%0d_cond", i), cond_o, vecs[i].instr[31:28]);
      checkOutput($sformatf("v%0d_class", i), class_o, vecs[i].cls);
      checkOutput($sformatf("v%0d_rn", i), rn_o, vecs[i].rn);
      checkOutput($sformatf("v%0d_rd", i), rd_o, vecs[i].rd);
      checkOutput($sformatf("v%0d_imm", i), imm_o, vecs[i].imm);
      checkOutput($sformatf("v%0d_sf", i), set_flags_o, vecs[i].sf);
      checkOutput($sformatf("v%0d_ld", i), load_o, vecs[i].ld);
      checkOutput($sformatf("v%0d_lk", i), link_o, vecs[i].lk);
      checkOutput($sformatf("v%0d_last", i), uop_last_o, 1);
      checkOutput($sformatf("v%0d_stall", i), stall_o, 0);
    end
    checkOutput("mul_rs", rs_o, 4'h0);

    // LDM r0-r2, next instruction held at the input until the block drains
    applyStimulus(1'b1, 32'hE8900007, 32'h200, 1'b0, 1'b0);
    checkOutput("ldm0_class", class_o, 3); checkOutput("ldm0_rd", rd_o, 0);
    checkOutput("ldm0_imm", imm_o, 0); checkOutput("ldm0_last", uop_last_o, 0);
    checkOutput("ldm0_ld", load_o, 1); checkOutput("ldm0_stall", stall_o, 1);
    applyStimulus(1'b1, 32'hE3A014FF, 32'h204, 1'b0, 1'b0);
    checkOutput("ldm1_valid", valid_o, 1); checkOutput("ldm1_rd", rd_o, 1);
    checkOutput("ldm1_imm", imm_o, 4); checkOutput("ldm1_last", uop_last_o, 0);
    checkOutput("ldm1_stall", stall_o, 1); checkOutput("ldm1_pc", pc_o, 32'h200);
    applyStimulus(1'b1, 32'hE3A014FF, 32'h204, 1'b0, 1'b0);
    checkOutput("ldm2_valid", valid_o, 1); checkOutput("ldm2_rd", rd_o, 2);
    checkOutput("ldm2_imm", imm_o, 8); checkOutput("ldm2_last", uop_last_o, 1);
    checkOutput("ldm2_stall", stall_o, 0);
    applyStimulus(1'b1, 32'hE3A014FF, 32'h204, 1'b0, 1'b0);
    checkOutput("ldm_next_pc", pc_o, 32'h204); checkOutput("ldm_next_class", class_o, 0);
    checkOutput("ldm_next_imm", imm_o, 32'hFF000000);

    // LDM with execute stall after the second micro-op
    applyStimulus(1'b1, 32'hE8900007, 32'h300, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hE3A0002A, 32'h304, 1'b0, 1'b0);
    checkOutput("stl1_rd", rd_o, 1);
    applyStimulus(1'b1, 32'hE3A0002A, 32'h304, 1'b1, 1'b0);
    checkOutput("stl_hold_valid", valid_o, 1); checkOutput("stl_hold_rd", rd_o, 1);
    checkOutput("stl_hold_imm", imm_o, 4); checkOutput("stl_hold_stall", stall_o, 1);
    applyStimulus(1'b1, 32'hE3A0002A, 32'h304, 1'b0, 1'b0);
    checkOutput("stl2_rd", rd_o, 2); checkOutput("stl2_imm", imm_o, 8);
    checkOutput("stl2_last", uop_last_o, 1);
    applyStimulus(1'b1, 32'hE3A0002A, 32'h304, 1'b0, 1'b0);
    checkOutput("stl_next_pc", pc_o, 32'h304);

    // LDM flushed on its second micro-op cycle
    applyStimulus(1'b1, 32'hE8900007, 32'h400, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hE3A0002A, 32'h404, 1'b0, 1'b0);
    checkOutput("fl1_rd", rd_o, 1);
    applyStimulus(1'b1, 32'hE3A0002A, 32'h404, 1'b0, 1'b1);
    checkOutput("fl_valid", valid_o, 0); checkOutput("fl_stall", stall_o, 0);
    applyStimulus(1'b1, 32'hE3A0002A, 32'h404, 1'b0, 1'b0);
    checkOutput("fl_next_valid", valid_o, 1); checkOutput("fl_next_pc", pc_o, 32'h404);
    checkOutput("fl_next_class", class_o, 0);

    // Flush beats a simultaneous stall
    applyStimulus(1'b1, 32'hE0000291, 32'h500, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hE3A0002A, 32'h504, 1'b1, 1'b1);
    checkOutput("flst_valid", valid_o, 0);
    applyStimulus(1'b1, 32'hE3A0002A, 32'h504, 1'b0, 1'b0);
    checkOutput("flst_next_pc", pc_o, 32'h504); checkOutput("flst_next_imm", imm_o, 32'h2A);

    // Random traffic against the queue model
    rst_n = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    rst_n = 1'b1;
    cur.valid = 1'b0;
    rem.delete();
    w  = 32'h0;
    pc = 32'h1000;
    v  = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (rem.size() == 0) begin
        w   = $urandom;
        sel = $urandom_range(0, 5);
        case (sel)
          1: begin
            w[27:25] = 3'b100;
            if ($urandom_range(0, 7) == 0) w[15:0] = 16'h0;
            else if ($urandom_range(0, 1) == 1) w[15:0] = 16'(1 << $urandom_range(0, 15));
          end
          2: begin w[27:22] = 6'b000000; w[7:4] = 4'b1001; end
          3: w[27:25] = 3'b101;
          4: w[27:25] = 3'b001;
          5: w[27:26] = 2'b01;
          default: ;
        endcase
        v  = ($urandom_range(0, 9) != 0);
        pc = pc + 32'd4;
      end
      st = ($urandom_range(0, 4) == 0);
      fl = ($urandom_range(0, 29) == 0);
      applyStimulus(v, w, pc, st, fl);
      model_edge(v, w, pc, st, fl);
      checkOutput("rnd_valid", valid_o, cur.valid);
      checkOutput("rnd_stall", stall_o, rem.size() > 0);
      if (cur.valid) begin
        checkOutput("rnd_pc", pc_o, cur.pc);
        checkOutput("rnd_cond", cond_o, cur.cond);
        checkOutput("rnd_class", class_o, cur.cls);
        checkOutput("rnd_opc", opc_o, cur.opc);
        checkOutput("rnd_rn", rn_o, cur.rn);
        checkOutput("rnd_rd", rd_o, cur.rd);
        checkOutput("rnd_rs", rs_o, cur.rs);
        checkOutput("rnd_rm", rm_o, cur.rm);
        checkOutput("rnd_imm", imm_o, cur.imm);
        checkOutput("rnd_sf", set_flags_o, cur.sf);
        checkOutput("rnd_ld", load_o, cur.ld);
        checkOutput("rnd_lk", link_o, cur.lk);
        checkOutput("rnd_last", uop_last_o, cur.last);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
